// File: rtl/axi_lite_cmd_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_regfile
//   AXI4-Lite command slave. Word index idx = addr[ADDR_WIDTH-1:log2(DW/8)]:
//     idx <  NUM_REGS   : general RW control registers (WSTRB byte-masked)
//     idx == NUM_REGS   : DOORBELL, write-only, pushes WDATA into the command FIFO
//     idx == NUM_REGS+1 : STATUS, read-only except W1C of the overflow sticky bit
//     anything else     : SLVERR, writes dropped, reads return 0
//   STATUS = {.., level[15:8], 5'b0, overflow, full, empty}.
//
// Ports
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   S_AXI_AW* / W* / B*    write address, write data, write response channels
//   S_AXI_AR* / R*         read address, read data channels
//   ctrl_regs              RW registers flattened, reg k at [k*DW +: DW]
//   cmd_tdata/tvalid/tready command FIFO head, first-word fall-through stream
//   w_state_dbg            write FSM state (0 idle, 1 ack, 2 resp)
//   r_state_dbg            read FSM state (0 idle, 1 data)
//
// Handshakes: every channel transfers on the rising edge where VALID and READY
// are both high; a VALID, once raised, is held with its payload until that edge.
// All AXI outputs come from flops or from the FSM state flops only.
// ---------------------------------------------------------------------------
module axi_lite_cmd_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_REGS   = 4,
   parameter int CMD_DEPTH  = 8
) (
   input  logic                           ACLK,
   input  logic                           ARESETN,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                     S_AXI_AWPROT,
   input  logic                           S_AXI_AWVALID,
   output logic                           S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                           S_AXI_WVALID,
   output logic                           S_AXI_WREADY,
   output logic [1:0]                     S_AXI_BRESP,
   output logic                           S_AXI_BVALID,
   input  logic                           S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                     S_AXI_ARPROT,
   input  logic                           S_AXI_ARVALID,
   output logic                           S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                     S_AXI_RRESP,
   output logic                           S_AXI_RVALID,
   input  logic                           S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
   output logic [DATA_WIDTH-1:0]          cmd_tdata,
   output logic                           cmd_tvalid,
   input  logic                           cmd_tready,
   output logic [1:0]                     w_state_dbg,
   output logic                           r_state_dbg
);

   localparam int STRBW    = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRBW);
   localparam int PTRW     = $clog2(CMD_DEPTH);
   localparam int CNTW     = $clog2(CMD_DEPTH + 1);
   localparam logic [31:0] DB_IDX = 32'(NUM_REGS);
   localparam logic [31:0] ST_IDX = 32'(NUM_REGS + 1);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   w_state_t              w_state, w_next;
   r_state_t              r_state, r_next;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] fifo_mem [CMD_DEPTH];
   logic [PTRW-1:0]       wr_ptr, rd_ptr;
   logic [CNTW-1:0]       fifo_count;
   logic                  fifo_full, ovf_q, arready_q;
   logic [31:0]           w_idx, r_idx;
   logic                  w_hs, ar_hs, wr_is_reg, wr_is_db, wr_is_st, wr_err;
   logic                  push_req, push_ok, pop;
   logic [DATA_WIDTH-1:0] status_word, rd_val;
   logic                  rd_err;
   logic                  unused_ok;

   // Protection bits and sub-word address bits carry no meaning here.
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   assign w_idx = 32'(S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB]);
   assign r_idx = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]);

   // ---------------- write FSM ----------------
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) w_state <= W_IDLE;
      else          w_state <= w_next;
   end

   // Address and data are only taken together, so one write is in flight.
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID) w_next = W_ACK;
         W_ACK:   w_next = W_RESP;
         W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      S_AXI_AWREADY = (w_state == W_ACK);
      S_AXI_WREADY  = (w_state == W_ACK);
      S_AXI_BVALID  = (w_state == W_RESP);
      w_state_dbg   = w_state;
   end

   assign w_hs      = (w_state == W_ACK);
   assign wr_is_reg = (w_idx < DB_IDX);
   assign wr_is_db  = (w_idx == DB_IDX);
   assign wr_is_st  = (w_idx == ST_IDX);
   assign fifo_full = (fifo_count == CNTW'(CMD_DEPTH));
   assign push_req  = w_hs && wr_is_db;
   // Fullness uses the pre-pop count: a push while full is refused even if
   // the consumer pops on the same edge.
   assign push_ok   = push_req && !fifo_full;
   assign pop       = cmd_tvalid && cmd_tready;
   assign wr_err    = !(wr_is_reg || wr_is_db || wr_is_st) || (wr_is_db && fifo_full);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
         S_AXI_BRESP <= RESP_OKAY;
         ovf_q       <= 1'b0;
      end else if (w_hs) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (w_idx == 32'(k)) begin
               for (int b = 0; b < STRBW; b++) begin
                  if (S_AXI_WSTRB[b]) regs[k][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
               end
            end
         end
         S_AXI_BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
         if (push_req && fifo_full) ovf_q <= 1'b1;
         else if (wr_is_st && S_AXI_WSTRB[0] && S_AXI_WDATA[2]) ovf_q <= 1'b0;
      end
   end

   always_comb begin
      ctrl_regs = '0;
      for (int k = 0; k < NUM_REGS; k++) ctrl_regs[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
   end

   // ---------------- command FIFO ----------------
   always_ff @(posedge ACLK) begin
      if (push_ok) fifo_mem[wr_ptr] <= S_AXI_WDATA;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push_ok) wr_ptr <= (wr_ptr == PTRW'(CMD_DEPTH - 1)) ? '0 : wr_ptr + PTRW'(1);
         if (pop)     rd_ptr <= (rd_ptr == PTRW'(CMD_DEPTH - 1)) ? '0 : rd_ptr + PTRW'(1);
         fifo_count <= fifo_count + CNTW'(push_ok) - CNTW'(pop);
      end
   end

   assign cmd_tdata  = fifo_mem[rd_ptr];
   assign cmd_tvalid = (fifo_count != '0);

   always_comb begin
      status_word       = '0;
      status_word[0]    = (fifo_count == '0);
      status_word[1]    = fifo_full;
      status_word[2]    = ovf_q;
      status_word[15:8] = 8'(fifo_count);
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

   assign ar_hs = arready_q && S_AXI_ARVALID;

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_DATA;
         R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      S_AXI_RVALID  = (r_state == R_DATA);
      S_AXI_ARREADY = arready_q;
      r_state_dbg   = r_state;
   end

   always_comb begin
      rd_val = '0;
      rd_err = 1'b0;
      if (r_idx < DB_IDX) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (r_idx == 32'(k)) rd_val = regs[k];
         end
      end else if (r_idx == ST_IDX) begin
         rd_val = status_word;
      end else if (r_idx != DB_IDX) begin
         rd_err = 1'b1;
      end
   end

   // ARREADY is a registered one-cycle pulse raised the cycle after ARVALID is
   // seen in idle; the read data is captured on the edge it is accepted.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         arready_q   <= 1'b0;
         S_AXI_RDATA <= '0;
         S_AXI_RRESP <= RESP_OKAY;
      end else begin
         arready_q <= (r_state == R_IDLE) && S_AXI_ARVALID && !arready_q;
         if (ar_hs) begin
            S_AXI_RDATA <= rd_val;
            S_AXI_RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_regfile.sv
module tb_axi_lite_cmd_regfile;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 4;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0]    awaddr = '0, araddr = '0;
   logic [2:0]       awprot = 3'b000, arprot = 3'b000;
   logic             awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [DW-1:0]    wdata = '0;
   logic [DW/8-1:0]  wstrb = '0;
   logic             awready, wready, bvalid, arready, rvalid;
   logic [1:0]       bresp, rresp;
   logic [DW-1:0]    rdata, cmd_tdata;
   logic             cmd_tvalid;
   logic             cmd_tready = 0;
   logic [NR*DW-1:0] ctrl_regs;
   logic [1:0]       w_state_dbg;
   logic             r_state_dbg;

   int n_checks = 0;
   int n_pass = 0;

   logic [DW-1:0] model_regs [NR];
   logic [DW-1:0] rd_exp_q[$];
   logic [1:0]    rresp_exp_q[$];
   logic [1:0]    bresp_exp_q[$];
   logic [DW-1:0] cmd_exp_q[$];
   logic [DW-1:0] mon_exp;

   axi_lite_cmd_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .CMD_DEPTH(DEPTH)) dut (
      .ACLK(clk), .ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .ctrl_regs(ctrl_regs), .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
      .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Command stream scoreboard: a word is consumed on the next rising edge.
   always @(negedge clk) begin
      #2;
      if (rst_n && cmd_tvalid && cmd_tready) begin
         n_checks++;
         if (cmd_exp_q.size() == 0) begin
            $display("FAIL cmd_pop: got %h, no word expected", cmd_tdata);
         end else begin
            mon_exp = cmd_exp_q.pop_front();
            if (cmd_tdata !== mon_exp) $display("FAIL cmd_pop: got %h, required %h", cmd_tdata, mon_exp);
            else n_pass++;
         end
      end
   end

   function automatic logic [NR*DW-1:0] pack_model();
      logic [NR*DW-1:0] v;
      for (int k = 0; k < NR; k++) v[k*DW +: DW] = model_regs[k];
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp, input bit pop_with_push);
      int waits;
      logic [1:0] e;
      bresp_exp_q.push_back(exp_resp);
      @(negedge clk);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!awready && waits < 20);
      n_checks++;
      if (!awready) begin
         $display("FAIL aw_handshake: no AWREADY within 20 cycles at addr %h", addr);
         awvalid = 0; wvalid = 0;
         void'(bresp_exp_q.pop_back());
         return;
      end else if (!wready || waits != 1) begin
         $display("FAIL aw_handshake: WREADY=%b latency=%0d, required WREADY=1 latency=1", wready, waits);
      end else n_pass++;
      if (pop_with_push) cmd_tready = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      if (pop_with_push) cmd_tready = 0;
      e = bresp_exp_q.pop_front();
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== e)
         $display("FAIL bresp addr %h: BVALID=%b BRESP=%b, required BVALID=1 BRESP=%b", addr, bvalid, bresp, e);
      else n_pass++;
      bready = 1;
      @(negedge clk);
      bready = 0;
      n_checks++;
      if (bvalid !== 1'b0) $display("FAIL b_release: BVALID=%b after BREADY, required 0", bvalid);
      else n_pass++;
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
      int waits;
      logic [DW-1:0] ed;
      logic [1:0] er;
      rd_exp_q.push_back(exp_data);
      rresp_exp_q.push_back(exp_resp);
      @(negedge clk);
      araddr = addr; arvalid = 1;
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!arready && waits < 20);
      n_checks++;
      if (!arready) begin
         $display("FAIL ar_handshake: no ARREADY within 20 cycles at addr %h", addr);
         arvalid = 0;
         void'(rd_exp_q.pop_back());
         void'(rresp_exp_q.pop_back());
         return;
      end else if (waits != 1) begin
         $display("FAIL ar_handshake: latency=%0d, required 1", waits);
      end else n_pass++;
      @(negedge clk);
      arvalid = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ed = rd_exp_q.pop_front();
      er = rresp_exp_q.pop_front();
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== ed || rresp !== er)
         $display("FAIL rdata addr %h: RVALID=%b RDATA=%h RRESP=%b, required 1 %h %b", addr, rvalid, rdata, rresp, ed, er);
      else n_pass++;
      rready = 1;
      @(negedge clk);
      rready = 0;
      n_checks++;
      if (rvalid !== 1'b0) $display("FAIL r_release: RVALID=%b after RREADY, required 0", rvalid);
      else n_pass++;
   endtask

   task automatic reg_write(input int idx, input logic [DW-1:0] data, input logic [3:0] strb);
      for (int b = 0; b < 4; b++) if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
      axi_write(AW'(idx * 4), data, strb, 2'b00, 0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (cmd_tvalid && n < 60) begin
         @(negedge clk);
         n++;
      end
      cmd_tready = 0;
      n_checks++;
      if (cmd_tvalid !== 1'b0 || cmd_exp_q.size() != 0)
         $display("FAIL drain: tvalid=%b words left=%0d, required 0 0", cmd_tvalid, cmd_exp_q.size());
      else n_pass++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int k = 0; k < NR; k++) model_regs[k] = '0;
      rst_n = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({awready, wready, bvalid, arready, rvalid} !== 5'b0)
         $display("FAIL reset_handshake: aw/w/b/ar/r=%b, required 00000", {awready, wready, bvalid, arready, rvalid});
      else n_pass++;
      n_checks++;
      if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== '0)
         $display("FAIL reset_resp: BRESP=%b RRESP=%b RDATA=%h, required 00 00 0", bresp, rresp, rdata);
      else n_pass++;
      rst_n = 1;
      @(negedge clk);
      n_checks++;
      if (ctrl_regs !== '0 || cmd_tvalid !== 1'b0 || w_state_dbg !== 2'd0 || r_state_dbg !== 1'b0)
         $display("FAIL reset_state: ctrl_regs=%h tvalid=%b wst=%0d rst=%0d, required 0 0 0 0",
                  ctrl_regs, cmd_tvalid, w_state_dbg, r_state_dbg);
      else n_pass++;
      axi_read(8'h14, 32'h0000_0001, 2'b00);
   endtask

   task automatic test_rw_regs();
      for (int k = 0; k < NR; k++) reg_write(k, DW'(k + 1), 4'hF);
      for (int k = 0; k < NR; k++) axi_read(AW'(k * 4), DW'(k + 1), 2'b00);
      n_checks++;
      if (ctrl_regs !== pack_model()) $display("FAIL ctrl_regs_rw: got %h, required %h", ctrl_regs, pack_model());
      else n_pass++;
   endtask

   task automatic test_strobe();
      int idx;
      logic [DW-1:0] d;
      reg_write(1, 32'hAABB_CCDD, 4'hF);
      reg_write(1, 32'h1122_3344, 4'b0101);
      axi_read(8'h05, 32'hAA22_CC44, 2'b00);
      repeat (5) begin
         idx = $urandom_range(0, NR - 1);
         d = $urandom;
         reg_write(idx, d, 4'($urandom_range(0, 15)));
      end
      for (int k = 0; k < NR; k++) axi_read(AW'(k * 4), model_regs[k], 2'b00);
      n_checks++;
      if (ctrl_regs !== pack_model()) $display("FAIL ctrl_regs_strobe: got %h, required %h", ctrl_regs, pack_model());
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [DW-1:0] d;
      cmd_tready = 0;
      for (int i = 0; i < DEPTH; i++) begin
         d = $urandom;
         cmd_exp_q.push_back(d);
         axi_write(8'h10, d, 4'hF, 2'b00, 0);
      end
      axi_write(8'h10, 32'hDEAD_BEEF, 4'h0, 2'b10, 0);
      axi_read(8'h14, 32'h0000_0806, 2'b00);
      axi_write(8'h14, 32'h0000_0004, 4'h1, 2'b00, 0);
      axi_read(8'h14, 32'h0000_0802, 2'b00);
      // push refused while full even though the head pops on the same edge
      axi_write(8'h10, 32'h0BAD_F00D, 4'hF, 2'b10, 1);
      axi_read(8'h14, 32'h0000_0704, 2'b00);
      axi_write(8'h14, 32'h0000_0004, 4'h1, 2'b00, 0);
      axi_read(8'h14, 32'h0000_0700, 2'b00);
      cmd_tready = 1;
      wait_drain();
      axi_read(8'h14, 32'h0000_0001, 2'b00);
      axi_read(8'h10, 32'h0000_0000, 2'b00);
   endtask

   task automatic test_stream();
      logic [DW-1:0] d;
      cmd_tready = 1;
      for (int i = 0; i < 3; i++) begin
         d = 32'hA1B2_C300 + DW'(i);
         cmd_exp_q.push_back(d);
         axi_write(8'h10, d, 4'hF, 2'b00, 0);
      end
      wait_drain();
      axi_read(8'h14, 32'h0000_0001, 2'b00);
      for (int i = 0; i < 3; i++) begin
         d = $urandom;
         cmd_exp_q.push_back(d);
         axi_write(8'h10, d, 4'hF, 2'b00, i == 2);
      end
      axi_read(8'h14, 32'h0000_0200, 2'b00);
      cmd_tready = 1;
      for (int i = 0; i < 20; i++) begin
         d = $urandom;
         cmd_exp_q.push_back(d);
         axi_write(8'h10, d, 4'hF, 2'b00, 0);
      end
      wait_drain();
      axi_read(8'h14, 32'h0000_0001, 2'b00);
   endtask

   task automatic test_bad_addr();
      axi_write(8'h18, 32'hFFFF_FFFF, 4'hF, 2'b10, 0);
      axi_read(8'h18, 32'h0, 2'b10);
      axi_write(8'hFC, 32'h1234_5678, 4'hF, 2'b10, 0);
      axi_read(8'hFC, 32'h0, 2'b10);
      n_checks++;
      if (ctrl_regs !== pack_model()) $display("FAIL bad_addr_regs: got %h, required %h", ctrl_regs, pack_model());
      else n_pass++;
      axi_read(8'h14, 32'h0000_0001, 2'b00);
   endtask

   task automatic test_aw_hold();
      bit seen = 0;
      @(negedge clk);
      awaddr = 8'h00; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1; wvalid = 0;
      repeat (10) begin
         @(negedge clk);
         if (awready || wready || bvalid) seen = 1;
      end
      awvalid = 0;
      n_checks++;
      if (seen || ctrl_regs !== pack_model())
         $display("FAIL aw_hold: ready/bvalid seen=%0d ctrl_regs=%h, required 0 %h", seen, ctrl_regs, pack_model());
      else n_pass++;
      reg_write(0, 32'h5A5A_0001, 4'hF);
      axi_read(8'h00, model_regs[0], 2'b00);
   endtask

   task automatic test_reset_mid();
      int waits = 0;
      cmd_tready = 0;
      cmd_exp_q.push_back(32'hC0DE_0001);
      axi_write(8'h10, 32'hC0DE_0001, 4'hF, 2'b00, 0);
      @(negedge clk);
      awaddr = 8'h08; wdata = 32'h0000_0077; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
      while (!awready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      n_checks++;
      if (bvalid !== 1'b1) $display("FAIL mid_resp: BVALID=%b, required 1", bvalid);
      else n_pass++;
      rst_n = 0;
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b0 || ctrl_regs !== '0 || cmd_tvalid !== 1'b0 || w_state_dbg !== 2'd0)
         $display("FAIL mid_reset: BVALID=%b ctrl_regs=%h tvalid=%b wst=%0d, required 0 0 0 0",
                  bvalid, ctrl_regs, cmd_tvalid, w_state_dbg);
      else n_pass++;
      cmd_exp_q.delete();
      for (int k = 0; k < NR; k++) model_regs[k] = '0;
      rst_n = 1;
      axi_read(8'h14, 32'h0000_0001, 2'b00);
      axi_read(8'h08, 32'h0, 2'b00);
   endtask

   initial begin
      test_reset();
      test_rw_regs();
      test_strobe();
      test_overflow();
      test_stream();
      test_bad_addr();
      test_aw_hold();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
